micro_issue_sequencer: RTL and testbench
========================================

Name: micro_issue_sequencer

Overview:
- Sits between the fetch/decode phase and the execute stage.
- Accepts one decoded bundle of MQ_N micro-instruction slots per x86 instruction (SCALE, LOAD, ARITH, STORE, RSRV1..3) and issues its non-nop slots one per cycle, in ascending slot index, over a valid/ready handshake.
- Back-pressures fetch while a bundle is draining and discards pending work on flush (taken jr / redirect).

Parameters:
- MQ_N, 7, number of micro-instruction slots per bundle.
- MIINST_W, 128, width in bits of one packed miinst_t.
- IDX_W, 3, width of the slot index; must satisfy 2**IDX_W >= MQ_N.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bundle_valid  in  1  fetch presents a complete bundle (the fetch phase's valid).
- bundle_ready  out  1  sequencer accepts the bundle this cycle.
- bundle_inst  in  MQ_N*MIINST_W  slot i occupies bits [i*MIINST_W +: MIINST_W].
- bundle_nop  in  MQ_N  bit i=1: slot i is nop and is never issued.
- issue_valid  out  1  issue_inst is valid.
- issue_ready  in  1  execute stage accepts.
- issue_inst  out  MIINST_W  micro-instruction being issued.
- issue_slot  out  IDX_W  slot index of issue_inst.
- issue_last  out  1  issue_inst is the final pending slot of its bundle.
- flush  in  1  discard the held bundle and everything pending.
- busy  out  1  a bundle is held (state ISSUE).

Behaviour:
- Storage: one bundle register buf[MQ_N] and a pending mask pend[MQ_N].
- States: IDLE (pend==0) and ISSUE (pend!=0).
- Reset: state IDLE, pend=0, issue_valid=0, issue_slot=0, issue_last=0, busy=0, bundle_ready=0 during rst. buf is don't-care.
- Accept condition: bundle_ready = !rst && !flush && (state==IDLE || (issue_valid && issue_ready && issue_last)).
  - bundle_ready depends combinationally on issue_ready.
  - This allows back-to-back bundles with no bubble.
- On accept: buf <= bundle_inst, pend <= ~bundle_nop. Issue starts the next cycle (latency 1).
- All-nop bundle (bundle_nop all ones): accepted, pend stays 0, state stays IDLE, nothing is issued.
- Issue:
  - issue_valid = (state==ISSUE).
  - sel = lowest set bit of pend; issue_inst = buf[sel], issue_slot = sel.
  - issue_last = (pend with sel cleared)==0.
  - issue_inst is a mux of registered state; it must remain stable while issue_valid && !issue_ready.
- Handshake: on issue_valid && issue_ready, pend[sel] <= 0.
  - If issue_last and a bundle is accepted in the same cycle, pend loads the new mask. The new mask overrides the clear.
- Flush: highest priority below rst. pend <= 0 next cycle and no bundle is accepted that cycle.
  - A slot handshaking in the flush cycle counts as issued; the execute stage owns its cancellation.
- Ordering: slots issue strictly in ascending index. No slot issues twice. No slot of bundle k+1 issues before the last slot of bundle k.
- busy = (state==ISSUE).

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_bundles[31:0] (accepted bundles, all-nop included), stat_uops[31:0] (issue handshakes) and stat_stall[31:0] (cycles with issue_valid && !issue_ready).
  - All three reset to 0 on rst, wrap modulo 2**32 and do not saturate.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Bundle with bundle_nop=7'b1110100 (slots 0,1,3 live), issue_ready=1 -> issue_slot 0,1,3 on cycles N+1..N+3. issue_last=1 only at slot 3. bundle_ready=0 at N+1,N+2 and 1 at N+3.
- Two bundles back-to-back, each with only slot 2 live, ready=1 -> slot 2 issued on consecutive cycles, no bubble between them, issue_last=1 each time.
- issue_ready held 0 for 3 cycles on slot 1 -> issue_inst/issue_slot stable for all 3 cycles, bundle_ready=0. With ISSUE_STATS_EN defined, stat_stall=3.
- All-nop bundle followed by a slot-4-only bundle -> no issue for the first bundle; slot 4 issues 1 cycle after the second bundle is accepted.
- flush asserted while slot 3 of 0,3,6 is pending (slot 0 already issued) -> slots 3 and 6 never issue, state IDLE next cycle, bundle_ready=0 in the flush cycle.
- rst asserted mid-bundle -> next cycle issue_valid=0, busy=0, pend=0. With ISSUE_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/micro_issue_sequencer.sv
// Holds one decoded bundle of MQ_N micro-instruction slots and issues the live slots one per cycle in ascending order.
// Optional build macro ISSUE_STATS_EN adds bundle/uop/stall counters.
module micro_issue_sequencer #(
    parameter int MQ_N     = 7,
    parameter int MIINST_W = 128,
    parameter int IDX_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bundle_valid,
    output logic                     bundle_ready,
    input  logic [MQ_N*MIINST_W-1:0] bundle_inst,
    input  logic [MQ_N-1:0]          bundle_nop,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [MIINST_W-1:0]      issue_inst,
    output logic [IDX_W-1:0]         issue_slot,
    output logic                     issue_last,
    input  logic                     flush,
    output logic                     busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]              stat_bundles,
    output logic [31:0]              stat_uops,
    output logic [31:0]              stat_stall
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]          state_reg;
    logic [0:0]          state_next;
    logic [MQ_N-1:0]     pend_reg;
    logic [MQ_N-1:0]     pend_next;
    logic [MIINST_W-1:0] buf_reg [MQ_N];
    logic [MIINST_W-1:0] slot_in [MQ_N];

    logic [IDX_W-1:0]    sel;
    logic [MQ_N-1:0]     sel_mask;
    logic [MQ_N-1:0]     pend_rest;
    logic                accept;
    logic                handshake;

    genvar gi;
    generate
        for (gi = 0; gi < MQ_N; gi++) begin : g_slot_unpack
            assign slot_in[gi] = bundle_inst[gi*MIINST_W +: MIINST_W];
        end
    endgenerate

    // Priority encoder: the loop runs high-to-low so the lowest pending slot wins.
    always_comb begin
        sel = '0;
        for (int i = MQ_N - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    assign sel_mask  = MQ_N'(1) << sel;
    assign pend_rest = pend_reg & ~sel_mask;

    assign issue_valid = (state_reg == ST_ISSUE);
    assign busy        = (state_reg == ST_ISSUE);
    assign issue_slot  = sel;
    assign issue_inst  = buf_reg[sel];
    assign issue_last  = issue_valid && (pend_rest == '0);
    assign handshake   = issue_valid && issue_ready;

    // Accepting while the last slot drains gives back-to-back bundles with no bubble.
    assign bundle_ready = !rst && !flush &&
                          ((state_reg == ST_IDLE) || (handshake && issue_last));
    assign accept       = bundle_valid && bundle_ready;

    always_comb begin
        pend_next = pend_reg;
        if (flush) begin
            pend_next = '0;
        end else if (accept) begin
            pend_next = ~bundle_nop;
        end else if (handshake) begin
            pend_next = pend_rest;
        end
        state_next = (pend_next != '0) ? ST_ISSUE : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg  <= '0;
            state_reg <= ST_IDLE;
        end else begin
            pend_reg  <= pend_next;
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_reg <= slot_in;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_bundles_reg;
    logic [31:0] stat_uops_reg;
    logic [31:0] stat_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bundles_reg <= '0;
            stat_uops_reg    <= '0;
            stat_stall_reg   <= '0;
        end else begin
            if (accept) begin
                stat_bundles_reg <= stat_bundles_reg + 32'd1;
            end
            if (handshake) begin
                stat_uops_reg <= stat_uops_reg + 32'd1;
            end
            if (issue_valid && !issue_ready) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_bundles = stat_bundles_reg;
    assign stat_uops    = stat_uops_reg;
    assign stat_stall   = stat_stall_reg;
`endif

endmodule

// File: tb/tb_micro_issue_sequencer.sv
// Bench for micro_issue_sequencer: queue-based model checked every cycle plus directed literal expectations.
module tb_micro_issue_sequencer;

    localparam int MQ_N     = 7;
    localparam int MIINST_W = 128;
    localparam int IDX_W    = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     bundle_valid;
    logic                     bundle_ready;
    logic [MQ_N*MIINST_W-1:0] bundle_inst;
    logic [MQ_N-1:0]          bundle_nop;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [MIINST_W-1:0]      issue_inst;
    logic [IDX_W-1:0]         issue_slot;
    logic                     issue_last;
    logic                     flush;
    logic                     busy;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_bundles, stat_uops, stat_stall;
    logic [31:0] m_bundles, m_uops, m_stall;
`endif

    micro_issue_sequencer #(.MQ_N(MQ_N), .MIINST_W(MIINST_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .bundle_inst(bundle_inst), .bundle_nop(bundle_nop),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst(issue_inst), .issue_slot(issue_slot), .issue_last(issue_last),
        .flush(flush), .busy(busy)
`ifdef ISSUE_STATS_EN
        , .stat_bundles(stat_bundles), .stat_uops(stat_uops), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]    slot;
        logic [MIINST_W-1:0] inst;
    } ent_t;

    ent_t q[$];
    int   hs_log[$];
    bit   model_ok = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [MIINST_W-1:0] mk_inst(input int b, input int s);
        return {32'hB000_0000 | 32'(b), 32'(s), 32'h5A5A_0000 ^ 32'(b * 7 + s), 32'(b * 131 + s * 17)};
    endfunction

    task automatic chk(input string name, input logic [MIINST_W-1:0] act, input logic [MIINST_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        checks++;
        if (hs_log != exp) begin
            failures++;
            $display("FAIL %s actual=%p required=%p", name, hs_log, exp);
        end
        hs_log.delete();
    endtask

    // Model: a bundle becomes a FIFO of its live slots; the head is what must be on the issue port.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_ok = 1'b1;
`ifdef ISSUE_STATS_EN
            m_bundles = 0; m_uops = 0; m_stall = 0;
`endif
        end else if (model_ok) begin
            bit acc, hs;
            acc = bundle_valid && !flush && (q.size() == 0 || (issue_ready && q.size() == 1));
            hs  = (q.size() != 0) && issue_ready;
`ifdef ISSUE_STATS_EN
            m_bundles += 32'(acc);
            m_uops    += 32'(hs);
            m_stall   += 32'((q.size() != 0) && !issue_ready);
`endif
            if (hs) begin
                hs_log.push_back(int'(q[0].slot));
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (acc) begin
                for (int i = 0; i < MQ_N; i++) begin
                    if (!bundle_nop[i]) begin
                        q.push_back('{slot: IDX_W'(i), inst: bundle_inst[i*MIINST_W +: MIINST_W]});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            bit ev;
            ev = (q.size() != 0);
            chk("issue_valid", issue_valid, ev);
            chk("busy", busy, ev);
            chk("bundle_ready", bundle_ready,
                !rst && !flush && (q.size() == 0 || (issue_ready && q.size() == 1)));
            if (ev) begin
                chk("issue_slot", issue_slot, q[0].slot);
                chk("issue_inst", issue_inst, q[0].inst);
                chk("issue_last", issue_last, q.size() == 1);
            end
`ifdef ISSUE_STATS_EN
            chk("stat_bundles", stat_bundles, m_bundles);
            chk("stat_uops", stat_uops, m_uops);
            chk("stat_stall", stat_stall, m_stall);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int b, input logic [MQ_N-1:0] nop);
        bundle_valid = 1'b1;
        bundle_nop   = nop;
        for (int i = 0; i < MQ_N; i++) begin
            bundle_inst[i*MIINST_W +: MIINST_W] = mk_inst(b, i);
        end
    endtask

    initial begin
        int bid;
        rst = 1'b1; bundle_valid = 1'b0; bundle_inst = '0; bundle_nop = '0;
        issue_ready = 1'b1; flush = 1'b0;
        tick(); tick();
        #2;
        chk("rst_ready", bundle_ready, 1'b0);
        chk("rst_valid", issue_valid, 1'b0);
        chk("rst_slot", issue_slot, 3'd0);
        chk("rst_last", issue_last, 1'b0);
        rst = 1'b0;
        tick();

        // Slots 0,1,3 live
        present(1, 7'b1110100);
        #2 chk("s1_accept_ready", bundle_ready, 1'b1);
        tick(); bundle_valid = 1'b0;
        #2 chk("s1_slot_a", issue_slot, 3'd0); chk("s1_ready_a", bundle_ready, 1'b0);
        tick();
        #2 chk("s1_slot_b", issue_slot, 3'd1); chk("s1_ready_b", bundle_ready, 1'b0);
        tick();
        #2 chk("s1_slot_c", issue_slot, 3'd3); chk("s1_last_c", issue_last, 1'b1);
        chk("s1_ready_c", bundle_ready, 1'b1);
        tick();
        chk_log("s1_order", '{0, 1, 3});

        // Back-to-back single-slot bundles
        present(2, 7'b1111011);
        tick(); present(3, 7'b1111011);
        #2 chk("s2_slot_a", issue_slot, 3'd2); chk("s2_last_a", issue_last, 1'b1);
        chk("s2_ready_a", bundle_ready, 1'b1); chk("s2_inst_a", issue_inst, mk_inst(2, 2));
        tick(); bundle_valid = 1'b0;
        #2 chk("s2_valid_b", issue_valid, 1'b1); chk("s2_inst_b", issue_inst, mk_inst(3, 2));
        tick();
        #2 chk("s2_idle", issue_valid, 1'b0);
        chk_log("s2_order", '{2, 2});

        // Stall on slot 1
        present(4, 7'b1111100);
        tick(); bundle_valid = 1'b0;
        tick(); issue_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #2 chk("s3_stall_slot", issue_slot, 3'd1);
            chk("s3_stall_inst", issue_inst, mk_inst(4, 1));
            chk("s3_stall_ready", bundle_ready, 1'b0);
            tick();
        end
        issue_ready = 1'b1;
        tick();
`ifdef ISSUE_STATS_EN
        chk("s3_stat_stall", stat_stall, 32'd3);
`endif
        chk_log("s3_order", '{0, 1});

        // All-nop bundle then slot-4-only bundle
        present(5, 7'b1111111);
        tick(); present(6, 7'b1101111);
        #2 chk("s4_nop_valid", issue_valid, 1'b0); chk("s4_nop_ready", bundle_ready, 1'b1);
        tick(); bundle_valid = 1'b0;
        #2 chk("s4_slot", issue_slot, 3'd4); chk("s4_last", issue_last, 1'b1);
        chk("s4_inst", issue_inst, mk_inst(6, 4));
        tick();
        chk_log("s4_order", '{4});

        // Flush with slot 3 of {0,3,6} pending
        present(7, 7'b0110110);
        tick(); bundle_valid = 1'b0;
        tick(); flush = 1'b1; issue_ready = 1'b0; present(8, 7'b0000000);
        #2 chk("s5_flush_ready", bundle_ready, 1'b0); chk("s5_flush_slot", issue_slot, 3'd3);
        tick(); flush = 1'b0; bundle_valid = 1'b0; issue_ready = 1'b1;
        #2 chk("s5_after_valid", issue_valid, 1'b0); chk("s5_after_busy", busy, 1'b0);
        tick(); tick();
        chk_log("s5_order", '{0});

        // Reset mid-bundle
        present(9, 7'b0000000);
        tick(); bundle_valid = 1'b0;
        tick(); tick(); rst = 1'b1;
        #2 chk("s6_rst_ready", bundle_ready, 1'b0);
        tick(); rst = 1'b0;
        #2 chk("s6_valid", issue_valid, 1'b0); chk("s6_busy", busy, 1'b0);
        chk("s6_slot", issue_slot, 3'd0); chk("s6_last", issue_last, 1'b0);
`ifdef ISSUE_STATS_EN
        chk("s6_stat_bundles", stat_bundles, 32'd0);
        chk("s6_stat_uops", stat_uops, 32'd0);
        chk("s6_stat_stall", stat_stall, 32'd0);
`endif
        chk_log("s6_order", '{0, 1});

        // Random traffic, checked by the per-cycle model only
        bid = 100;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) present(bid, MQ_N'($urandom) | MQ_N'($urandom));
            else bundle_valid = 1'b0;
            bid++;
            issue_ready = ($urandom_range(3) != 0);
            flush       = ($urandom_range(24) == 0);
            rst         = ($urandom_range(80) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; bundle_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
